instr_register_alu_pipe: RTL and testbench

Parametrised next-generation instruction register. It accepts instruction writes, computes each result in a 2-stage pipelined ALU, and commits the full instruction word into a DEPTH-entry array. Reads use a ready/valid handshake that stalls on in-flight hazards. Per-entry valid and divide-by-zero status are tracked. It sits between the instruction source (test driver or fetch logic) and the consumer of executed instruction words.

---
 rtl/instr_register_alu_pipe_pkg.sv | 49 ++++
 rtl/instr_register_alu_pipe_if.sv | 47 ++++
 rtl/instr_register_alu_pipe_alu.sv | 115 +++++++++++
 rtl/instr_register_alu_pipe.sv | 141 ++++++++++++++
 tb/tb_instr_register_alu_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared opcode encodings, operand/result types and the
//               instruction word layout for the instruction register pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    localparam int OP_WIDTH_DEFAULT = 32;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    // Codes 8-15 are legal on the bus; they are carried through unchanged.
    typedef enum logic [3:0] {
        ZERO  = OPC_ZERO,
        PASSA = OPC_PASSA,
        PASSB = OPC_PASSB,
        ADD   = OPC_ADD,
        SUB   = OPC_SUB,
        MULT  = OPC_MULT,
        DIV   = OPC_DIV,
        MOD   = OPC_MOD
    } opcode_t;

    typedef logic signed [OP_WIDTH_DEFAULT-1:0]   operand_t;
    typedef logic signed [2*OP_WIDTH_DEFAULT-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;

    // Packed width of {opc, op_a, op_b, result} for a given operand width.
    function automatic int instr_width(input int op_w);
        return 4 + 4 * op_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_register_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_alu_pipe_if
// Description : Write/read bus between the instruction source and the
//               instruction register pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_register_alu_pipe_if #(
    parameter int OP_WIDTH   = 32,
    parameter int ADDR_WIDTH = 5
);
    import instr_register_pkg::*;

    localparam int IW_WIDTH = instr_width(OP_WIDTH);

    logic                         load_en;
    logic [ADDR_WIDTH-1:0]        write_pointer;
    opcode_t                      opcode;
    logic signed [OP_WIDTH-1:0]   operand_a;
    logic signed [OP_WIDTH-1:0]   operand_b;
    logic                         read_en;
    logic [ADDR_WIDTH-1:0]        read_pointer;
    logic                         read_ready;
    logic                         read_valid;
    logic [IW_WIDTH-1:0]          instruction_word;
    logic                         read_err;
    logic                         div_zero;
    logic                         write_err;
    logic [ADDR_WIDTH:0]          occupancy;
    logic                         parity_err;

    modport master (
        output load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer,
        input  read_ready, read_valid, instruction_word, read_err,
               div_zero, write_err, occupancy, parity_err
    );

    modport slave (
        input  load_en, write_pointer, opcode, operand_a, operand_b,
               read_en, read_pointer,
        output read_ready, read_valid, instruction_word, read_err,
               div_zero, write_err, occupancy, parity_err
    );

endinterface
`default_nettype wire

// File: rtl/instr_register_alu_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module      : instr_alu_stage
// Description : S1 operand capture, combinational ALU, S2 result register.
//               Exposes stage valid/address for read hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_alu_stage
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH   = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int IW_WIDTH   = 4 + 4 * OP_WIDTH
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       i_load_en,
    input  wire logic [ADDR_WIDTH-1:0]      i_write_pointer,
    input  wire opcode_t                    i_opcode,
    input  wire logic signed [OP_WIDTH-1:0] i_operand_a,
    input  wire logic signed [OP_WIDTH-1:0] i_operand_b,
    output logic                            o_write_err,
    output logic                            o_s1_valid,
    output logic [ADDR_WIDTH-1:0]           o_s1_addr,
    output logic                            o_s2_valid,
    output logic [ADDR_WIDTH-1:0]           o_s2_addr,
    output logic [IW_WIDTH-1:0]             o_s2_word,
    output logic                            o_s2_div_zero
);
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic                            r_s1_valid;
    logic [ADDR_WIDTH-1:0]           r_s1_addr;
    opcode_t                         r_s1_opc;
    logic signed [OP_WIDTH-1:0]      r_s1_a;
    logic signed [OP_WIDTH-1:0]      r_s1_b;
    logic                            r_s2_valid;
    logic [ADDR_WIDTH-1:0]           r_s2_addr;
    logic [IW_WIDTH-1:0]             r_s2_word;
    logic                            r_s2_dz;
    logic                            r_write_err;

    logic                            w_in_range;
    logic signed [2*OP_WIDTH-1:0]    w_a;
    logic signed [2*OP_WIDTH-1:0]    w_b;
    logic signed [2*OP_WIDTH-1:0]    w_result;
    logic                            w_dz;

    assign w_in_range = {1'b0, i_write_pointer} < c_DEPTH;
    assign w_a = {{OP_WIDTH{r_s1_a[OP_WIDTH-1]}}, r_s1_a};
    assign w_b = {{OP_WIDTH{r_s1_b[OP_WIDTH-1]}}, r_s1_b};

    // Double-width signed arithmetic: MULT cannot overflow, DIV/MOD truncate.
    always_comb begin
        w_result = '0;
        w_dz     = 1'b0;
        case (r_s1_opc)
            PASSA:   w_result = w_a;
            PASSB:   w_result = w_b;
            ADD:     w_result = w_a + w_b;
            SUB:     w_result = w_a - w_b;
            MULT:    w_result = w_a * w_b;
            DIV: begin
                if (w_b == '0) w_dz = 1'b1;
                else           w_result = w_a / w_b;
            end
            MOD: begin
                if (w_b == '0) w_dz = 1'b1;
                else           w_result = w_a % w_b;
            end
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_opc    <= ZERO;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_word   <= '0;
            r_s2_dz     <= 1'b0;
            r_write_err <= 1'b0;
        end else begin
            r_s1_valid  <= i_load_en && w_in_range;
            r_write_err <= i_load_en && !w_in_range;
            if (i_load_en) begin
                r_s1_addr <= i_write_pointer;
                r_s1_opc  <= i_opcode;
                r_s1_a    <= i_operand_a;
                r_s1_b    <= i_operand_b;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_addr <= r_s1_addr;
                r_s2_word <= {r_s1_opc, r_s1_a, r_s1_b, w_result};
                r_s2_dz   <= w_dz;
            end
        end
    end

    assign o_write_err   = r_write_err;
    assign o_s1_valid    = r_s1_valid;
    assign o_s1_addr     = r_s1_addr;
    assign o_s2_valid    = r_s2_valid;
    assign o_s2_addr     = r_s2_addr;
    assign o_s2_word     = r_s2_word;
    assign o_s2_div_zero = r_s2_dz;

endmodule
`default_nettype wire

// File: rtl/instr_register_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_alu_pipe
// Description : DEPTH-entry instruction register fed by a 2-stage ALU, with
//               hazard-stalled ready/valid reads. Optional: IR_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_register_alu_pipe
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH   = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  wire logic                clk,
    input  wire logic                reset,
    instr_register_alu_pipe_if.slave bus
);
    localparam int                  IW_WIDTH = instr_width(OP_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);

    typedef struct packed {
        opcode_t                      opc;
        logic signed [OP_WIDTH-1:0]   op_a;
        logic signed [OP_WIDTH-1:0]   op_b;
        logic signed [2*OP_WIDTH-1:0] result;
    } entry_t;

    logic                  w_s1_valid;
    logic [ADDR_WIDTH-1:0] w_s1_addr;
    logic                  w_s2_valid;
    logic [ADDR_WIDTH-1:0] w_s2_addr;
    logic [IW_WIDTH-1:0]   w_s2_word;
    logic                  w_s2_dz;
    logic                  w_write_err;

    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_dz;
    entry_t                r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_occupancy;
    logic                  r_read_valid;
    logic                  r_read_err;
    logic                  r_div_zero;
    entry_t                r_instr_word;

    logic                  w_rd_in_range;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_rd_err;
    logic                  w_hazard;
    logic                  w_read_ready;

    instr_alu_stage #(
        .OP_WIDTH   (OP_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IW_WIDTH   (IW_WIDTH)
    ) u_alu_stage (
        .clk             (clk),
        .reset           (reset),
        .i_load_en       (bus.load_en),
        .i_write_pointer (bus.write_pointer),
        .i_opcode        (bus.opcode),
        .i_operand_a     (bus.operand_a),
        .i_operand_b     (bus.operand_b),
        .o_write_err     (w_write_err),
        .o_s1_valid      (w_s1_valid),
        .o_s1_addr       (w_s1_addr),
        .o_s2_valid      (w_s2_valid),
        .o_s2_addr       (w_s2_addr),
        .o_s2_word       (w_s2_word),
        .o_s2_div_zero   (w_s2_dz)
    );

    // Stall while the requested entry has a write anywhere in flight, so a
    // read can never race the commit of the same entry.
    assign w_hazard = (bus.load_en && bus.write_pointer == bus.read_pointer) ||
                      (w_s1_valid  && w_s1_addr == bus.read_pointer) ||
                      (w_s2_valid  && w_s2_addr == bus.read_pointer);
    assign w_read_ready  = bus.read_en && !w_hazard && !reset;
    assign w_rd_in_range = {1'b0, bus.read_pointer} < c_DEPTH;
    assign w_rd_idx      = w_rd_in_range ? bus.read_pointer : '0;
    assign w_rd_err      = !w_rd_in_range || !r_valid[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_s2_valid) r_mem[w_s2_addr] <= entry_t'(w_s2_word);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_dz         <= '0;
            r_occupancy  <= '0;
            r_read_valid <= 1'b0;
            r_read_err   <= 1'b0;
            r_div_zero   <= 1'b0;
            r_instr_word <= '0;
        end else begin
            r_read_valid <= w_read_ready;
            if (w_read_ready) begin
                r_read_err   <= w_rd_err;
                r_div_zero   <= !w_rd_err && r_dz[w_rd_idx];
                r_instr_word <= w_rd_err ? '0 : r_mem[w_rd_idx];
            end
            if (w_s2_valid) begin
                r_valid[w_s2_addr] <= 1'b1;
                r_dz[w_s2_addr]    <= w_s2_dz;
                if (!r_valid[w_s2_addr])
                    r_occupancy <= r_occupancy + (ADDR_WIDTH+1)'(1);
            end
        end
    end

`ifdef IR_PARITY_EN
    logic [DEPTH-1:0] r_parity;
    logic             r_parity_err;

    always_ff @(posedge clk) begin
        if (w_s2_valid) r_parity[w_s2_addr] <= ^w_s2_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_parity_err <= 1'b0;
        else if (w_read_ready) r_parity_err <= !w_rd_err &&
                                   ((^r_mem[w_rd_idx]) != r_parity[w_rd_idx]);
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.read_ready       = w_read_ready;
    assign bus.read_valid       = r_read_valid;
    assign bus.instruction_word = r_instr_word;
    assign bus.read_err         = r_read_err;
    assign bus.div_zero         = r_div_zero;
    assign bus.write_err        = w_write_err;
    assign bus.occupancy        = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_instr_register_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_register_alu_pipe
// Description : Directed and randomized bench for instr_register_alu_pipe
//               (DEPTH=20) against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_register_alu_pipe;
    import instr_register_pkg::*;

    localparam int OPW   = 32;
    localparam int DEPTH = 20;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_register_alu_pipe_if #(.OP_WIDTH(OPW), .ADDR_WIDTH(AW)) bus ();

    instr_register_alu_pipe #(
        .OP_WIDTH   (OPW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus for the next cycle
    bit          d_rst, d_load, d_ren;
    logic [AW-1:0] d_wptr, d_rptr;
    logic [3:0]  d_opc;
    logic [31:0] d_a, d_b;

    // reference model: committed contents plus writes still in flight
    bit           m_valid [DEPTH];
    logic [131:0] m_word  [DEPTH];
    bit           m_dz    [DEPTH];
    bit           h1v, h2v, h1dz, h2dz;
    logic [AW-1:0] h1p, h2p;
    logic [131:0] h1w, h2w;
    bit           pend_rd, pend_err, pend_dz, prev_werr, last_accept;
    logic [131:0] pend_word;

    logic [131:0] obs_word;
    bit           obs_err, obs_dz, obs_werr;
    int           obs_occ;

    function automatic void ref_exec(input logic [3:0] opc, input logic [31:0] a,
                                     input logic [31:0] b, output logic [131:0] w,
                                     output bit dz);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        dz = 1'b0;
        case (opc)
            4'd1: r = sa;
            4'd2: r = sb;
            4'd3: r = sa + sb;
            4'd4: r = sa - sb;
            4'd5: r = sa * sb;
            4'd6: if (sb == 0) dz = 1'b1; else r = sa / sb;
            4'd7: if (sb == 0) dz = 1'b1; else r = sa % sb;
            default: r = 0;
        endcase
        w = {opc, a, b, 64'(r)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        h1v = 0; h2v = 0; pend_rd = 0; prev_werr = 0; last_accept = 0;
    endtask

    task automatic cycle();
        bit exp_ready;
        int occ;
        reset             = d_rst;
        bus.load_en       = d_load;
        bus.write_pointer = d_wptr;
        bus.opcode        = opcode_t'(d_opc);
        bus.operand_a     = d_a;
        bus.operand_b     = d_b;
        bus.read_en       = d_ren;
        bus.read_pointer  = d_rptr;
        if (d_rst) model_clear();
        @(negedge clk);
        exp_ready = !d_rst && d_ren && !(d_load && d_wptr == d_rptr) &&
                    !(h1v && h1p == d_rptr) && !(h2v && h2p == d_rptr);
        check("read_ready", bus.read_ready, exp_ready);
        check("read_valid", bus.read_valid, pend_rd);
        if (pend_rd) begin
            check("instruction_word", bus.instruction_word, pend_word);
            check("read_err", bus.read_err, pend_err);
            check("div_zero", bus.div_zero, pend_dz);
            check("parity_err", bus.parity_err, 1'b0);
            obs_word = bus.instruction_word;
            obs_err  = bus.read_err;
            obs_dz   = bus.div_zero;
        end
        check("write_err", bus.write_err, prev_werr);
        obs_werr = bus.write_err;
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(m_valid[i]);
        check("occupancy", bus.occupancy, occ);
        obs_occ = int'(bus.occupancy);
        @(posedge clk);
        if (!d_rst) begin
            last_accept = exp_ready;
            pend_rd     = exp_ready;
            if (exp_ready) begin
                pend_err  = !(d_rptr < DEPTH && m_valid[d_rptr]);
                pend_word = pend_err ? '0 : m_word[d_rptr];
                pend_dz   = pend_err ? 1'b0 : m_dz[d_rptr];
            end
            if (h2v) begin
                m_valid[h2p] = 1'b1;
                m_word[h2p]  = h2w;
                m_dz[h2p]    = h2dz;
            end
            h2v = h1v; h2p = h1p; h2w = h1w; h2dz = h1dz;
            h1v = d_load && d_wptr < DEPTH;
            h1p = d_wptr;
            ref_exec(d_opc, d_a, d_b, h1w, h1dz);
            prev_werr = d_load && d_wptr >= DEPTH;
        end
        #1;
    endtask

    task automatic idle(input int n);
        d_load = 0; d_ren = 0;
        repeat (n) cycle();
    endtask

    task automatic write(input int ptr, input logic [3:0] opc,
                         input logic [31:0] a, input logic [31:0] b);
        d_load = 1; d_wptr = AW'(ptr); d_opc = opc; d_a = a; d_b = b;
        cycle();
        d_load = 0;
    endtask

    task automatic read(input int ptr);
        d_ren = 1; d_rptr = AW'(ptr);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_accept) break;
        end
        if (!last_accept) check("read_timeout", 1'b0, 1'b1);
        d_ren = 0;
        cycle();
    endtask

    initial begin
        int stalls;
        d_rst = 1; d_load = 0; d_ren = 0; d_wptr = '0; d_rptr = '0;
        d_opc = '0; d_a = '0; d_b = '0;
        model_clear();
        cycle(); cycle();
        d_rst = 0;
        cycle();

        // unwritten entry after reset
        read(5);
        check("rst_rd_err", obs_err, 1'b1);
        check("rst_rd_word", obs_word, 132'd0);
        check("rst_occ", obs_occ, 0);

        write(2, 4'd3, -32'sd7, 32'sd3);
        idle(2);
        read(2);
        check("add_result", obs_word[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("add_opc", obs_word[131:128], 4'd3);
        check("add_err", obs_err, 1'b0);
        check("add_occ", obs_occ, 1);

        write(4, 4'd6, 32'sd9, 32'sd0);
        write(5, 4'd7, -32'sd7, 32'sd2);
        read(4);
        check("div0_result", obs_word[63:0], 64'd0);
        check("div0_flag", obs_dz, 1'b1);
        read(5);
        check("mod_result", obs_word[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("mod_flag", obs_dz, 1'b0);

        // read issued together with the write to the same entry
        d_load = 1; d_wptr = 0; d_opc = 4'd5; d_a = 32'h7FFF_FFFF; d_b = 32'd2;
        d_ren = 1; d_rptr = 0;
        cycle();
        d_load = 0;
        stalls = last_accept ? 0 : 1;
        for (int k = 0; k < 10 && !last_accept; k++) begin
            cycle();
            if (!last_accept) stalls++;
        end
        d_ren = 0;
        cycle();
        check("hazard_stalls", stalls, 3);
        check("mult_result", obs_word[63:0], 64'h0000_0000_FFFF_FFFE);

        write(25, 4'd1, 32'd1, 32'd0);
        cycle();
        check("write_err_pulse", obs_werr, 1'b1);
        idle(3);
        check("oob_occ", obs_occ, 4);
        write(19, 4'd1, 32'd1, 32'd0);
        write(19, 4'd1, 32'd2, 32'd0);
        idle(3);
        check("b2b_occ", obs_occ, 5);
        read(19);
        check("b2b_result", obs_word[63:0], 64'd2);

        write(7, 4'd1, 32'd5, 32'd0);
        d_rst = 1;
        cycle(); cycle();
        d_rst = 0;
        cycle();
        read(7);
        check("rst_inflight_err", obs_err, 1'b1);
        check("rst_inflight_occ", obs_occ, 0);

        for (int n = 0; n < 400; n++) begin
            d_load = 1'($urandom_range(0, 1));
            d_wptr = AW'($urandom_range(0, 23));
            d_opc  = 4'($urandom_range(0, 15));
            d_a    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
            d_b    = ($urandom_range(0, 4) == 0) ? 32'd0 :
                     ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10);
            if (!d_ren || last_accept) begin
                d_ren  = 1'($urandom_range(0, 1));
                d_rptr = AW'($urandom_range(0, 21));
            end
            cycle();
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
